// File: rtl/seq_detect_if.sv
// -----------------------------------------------------------------------------
// seq_detect_if
// Serial-stream bundle for the pattern detector.
//   din  : serial data bit, one bit per rising clock edge (master -> slave)
//   flag : one-cycle registered match pulse            (slave  -> master)
// Handshake semantics: there is no valid/ready pair. din is consumed on every
// rising edge that is not a reset edge, and flag is a plain registered pulse
// with no back-pressure, so the consumer must sample it every cycle.
// -----------------------------------------------------------------------------
interface seq_detect_if;
  logic din;
  logic flag;

  modport master (output din, input flag);
  modport slave  (input din, output flag);
endinterface

// File: rtl/seq_detect_fsm.sv
// -----------------------------------------------------------------------------
// seq_detect_fsm
// Serial bit-pattern detector. Each rising edge samples bus.din; bus.flag
// pulses for one cycle after the edge on which the most recent PAT_LEN bits
// equal PATTERN (MSB of PATTERN = oldest bit).
//
// Ports:
//   clk       : system clock, all state changes on the rising edge
//   rst_n     : synchronous reset, ACTIVE-HIGH despite its name
//   bus       : seq_detect_if slave modport (din in, flag out)
//   dbg_state : current FSM state (= length of the matched prefix)
//
// Implementation: a KMP automaton with one state per matched-prefix length
// 0..PAT_LEN-1. The transition tables are computed at elaboration time from
// PATTERN, so the runtime logic is just two table lookups and a few flops.
// -----------------------------------------------------------------------------
module seq_detect_fsm #(
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b10010,
  parameter logic               OVERLAP = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  seq_detect_if.slave                bus,
  output logic [$clog2(PAT_LEN)-1:0] dbg_state
);

  localparam int STATE_W = $clog2(PAT_LEN);
  // Table entries must also hold PAT_LEN itself ("full match reached").
  localparam int LEN_W   = $clog2(PAT_LEN + 1);

  localparam logic [STATE_W-1:0] IDLE = '0;

  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
    $error("seq_detect_fsm: PAT_LEN must be in 2..16");
  end

  // PATTERN re-ordered so that index 0 is the oldest (first-received) bit.
  function automatic logic [15:0] pat_oldest_first();
    logic [15:0] pw;
    logic [15:0] r;
    pw = 16'(PATTERN);
    r  = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < PAT_LEN) r[4'(i)] = pw[4'(PAT_LEN - 1 - i)];
    end
    return r;
  endfunction

  localparam logic [15:0] PAT_OF = pat_oldest_first();

  // Longest k <= max_k such that the last k bits of t (n bits, index 0 oldest)
  // equal the first k bits of the pattern.
  function automatic int border_len(input logic [15:0] t, input int n, input int max_k);
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k <= max_k && k <= n) begin
        ok = 1'b1;
        for (int j = 0; j < 16; j++) begin
          if (j < k) begin
            if (t[4'(n - k + j)] != PAT_OF[4'(j)]) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  // Matched length after receiving bit b while s bits of the prefix are held.
  function automatic int next_len(input int s, input logic b);
    logic [15:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < s) t[4'(i)] = PAT_OF[4'(i)];
    end
    t[4'(s)] = b;
    return border_len(t, s + 1, s + 1);
  endfunction

  // Failure value of the full pattern: where an overlapping search resumes.
  localparam int FAIL_LEN = border_len(PAT_OF, PAT_LEN, PAT_LEN - 1);

  logic [LEN_W-1:0] nxt0 [PAT_LEN];
  logic [LEN_W-1:0] nxt1 [PAT_LEN];

  for (genvar s = 0; s < PAT_LEN; s++) begin : g_tab
    localparam int N0 = next_len(s, 1'b0);
    localparam int N1 = next_len(s, 1'b1);
    assign nxt0[s] = LEN_W'(N0);
    assign nxt1[s] = LEN_W'(N1);
  end

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_d;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_d;
  logic [LEN_W-1:0]   adv;
  logic               full_len;
  logic               hit;
  logic               flag_q;

  always_comb begin
    adv      = bus.din ? nxt1[state] : nxt0[state];
    full_len = (adv == LEN_W'(PAT_LEN));
    // The automaton can only reach full length after PAT_LEN real bits, but
    // the fill guard makes the "no match from reset history" rule explicit.
    hit      = full_len && (fill >= LEN_W'(PAT_LEN - 1));

    if (full_len) state_d = OVERLAP ? STATE_W'(FAIL_LEN) : IDLE;
    else          state_d = STATE_W'(adv);

    if (hit && !OVERLAP)              fill_d = '0;
    else if (fill == LEN_W'(PAT_LEN)) fill_d = fill;
    else                              fill_d = fill + LEN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state  <= IDLE;
      fill   <= '0;
      flag_q <= 1'b0;
    end else begin
      state  <= state_d;
      fill   <= fill_d;
      flag_q <= hit;
    end
  end

  assign bus.flag  = flag_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_fsm
// Four detector instances share clk/rst_n/din:
//   a: 10010, overlap    b: 10010, no overlap
//   c: 00000, overlap    d: 11 (PAT_LEN=2), no overlap
// -----------------------------------------------------------------------------
module tb_seq_detect_fsm;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic din;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_detect_if if_a ();
  seq_detect_if if_b ();
  seq_detect_if if_c ();
  seq_detect_if if_d ();

  assign if_a.din = din;
  assign if_b.din = din;
  assign if_c.din = din;
  assign if_d.din = din;

  logic [2:0] dbg_a;
  logic [2:0] dbg_b;
  logic [2:0] dbg_c;
  logic [0:0] dbg_d;

  seq_detect_fsm #(.PAT_LEN(5), .PATTERN(5'b10010), .OVERLAP(1'b1))
    u_a (.clk(clk), .rst_n(rst_n), .bus(if_a), .dbg_state(dbg_a));
  seq_detect_fsm #(.PAT_LEN(5), .PATTERN(5'b10010), .OVERLAP(1'b0))
    u_b (.clk(clk), .rst_n(rst_n), .bus(if_b), .dbg_state(dbg_b));
  seq_detect_fsm #(.PAT_LEN(5), .PATTERN(5'b00000), .OVERLAP(1'b1))
    u_c (.clk(clk), .rst_n(rst_n), .bus(if_c), .dbg_state(dbg_c));
  seq_detect_fsm #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b0))
    u_d (.clk(clk), .rst_n(rst_n), .bus(if_d), .dbg_state(dbg_d));

  logic act [4];
  assign act[0] = if_a.flag;
  assign act[1] = if_b.flag;
  assign act[2] = if_c.flag;
  assign act[3] = if_d.flag;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Sliding window of recent bits plus count of bits eligible for a match.
  int          lens [4];
  logic [15:0] pats [4];
  logic        ovls [4];
  logic [15:0] win  [4];
  int          cnt  [4];
  logic        mexp [4];

  task automatic model_step(input logic r, input logic d);
    logic [15:0] mask;
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        win[i]  = '0;
        cnt[i]  = 0;
        mexp[i] = 1'b0;
      end else begin
        win[i] = {win[i][14:0], d};
        if (cnt[i] < 16) cnt[i]++;
        mask    = 16'((17'h1 << lens[i]) - 17'h1);
        mexp[i] = (cnt[i] >= lens[i]) && ((win[i] & mask) == pats[i]);
        if (mexp[i] && !ovls[i]) cnt[i] = 0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic d);
    @(negedge clk);
    rst_n = r;
    din   = d;
    @(posedge clk);
    model_step(r, d);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       din;
    logic [3:0] exp;   // bit0=a bit1=b bit2=c bit3=d
  } vec_t;

  vec_t vecs [$];

  function automatic void add(input logic r, input logic d, input logic [3:0] e);
    vec_t v;
    v.rst = r;
    v.din = d;
    v.exp = e;
    vecs.push_back(v);
  endfunction

  string nm [4];

  initial begin
    nm[0] = "a"; nm[1] = "b"; nm[2] = "c"; nm[3] = "d";
    lens[0] = 5; pats[0] = 16'b10010; ovls[0] = 1'b1;
    lens[1] = 5; pats[1] = 16'b10010; ovls[1] = 1'b0;
    lens[2] = 5; pats[2] = 16'b00000; ovls[2] = 1'b1;
    lens[3] = 2; pats[3] = 16'b11;    ovls[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      win[i] = '0; cnt[i] = 0; mexp[i] = 1'b0;
    end
    rst_n = 1'b1;
    din   = 1'b0;

    // reset, two cycles
    add(1, 0, 4'b0000); add(1, 0, 4'b0000);
    // 1,0,0,1,0,0,1,0 : a pulses after 5 and 8, b only after 5
    add(0, 1, 4'b0000); add(0, 0, 4'b0000); add(0, 0, 4'b0000); add(0, 1, 4'b0000);
    add(0, 0, 4'b0011); add(0, 0, 4'b0000); add(0, 1, 4'b0000); add(0, 0, 4'b0001);
    // reset mid-sequence (din=1 on the reset edge must be ignored)
    add(1, 0, 4'b0000); add(0, 1, 4'b0000); add(0, 0, 4'b0000); add(0, 0, 4'b0000);
    add(1, 1, 4'b0000); add(0, 1, 4'b0000); add(0, 0, 4'b0000);
    // reset collides with the completing bit
    add(1, 0, 4'b0000); add(0, 1, 4'b0000); add(0, 0, 4'b0000); add(0, 0, 4'b0000);
    add(0, 1, 4'b0000); add(1, 0, 4'b0000); add(0, 0, 4'b0000);
    // zeros from reset: c fires on the 5th bit, then every cycle
    add(1, 0, 4'b0000);
    add(0, 0, 4'b0000); add(0, 0, 4'b0000); add(0, 0, 4'b0000); add(0, 0, 4'b0000);
    add(0, 0, 4'b0100); add(0, 0, 4'b0100); add(0, 0, 4'b0100);
    // ones from reset: d (11, no overlap) fires on every second bit
    add(1, 0, 4'b0000);
    add(0, 1, 4'b0000); add(0, 1, 4'b1000); add(0, 1, 4'b0000);
    add(0, 1, 4'b1000); add(0, 1, 4'b0000); add(0, 1, 4'b1000);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].din);
      for (int k = 0; k < 4; k++)
        check($sformatf("vec%0d_%s", i, nm[k]), {7'd0, act[k]}, {7'd0, vecs[i].exp[k]});
    end

    // hand sequence: state after reset, and prefix tracking for a
    drive(1, 0);
    check("rst_state_a", {5'd0, dbg_a}, 8'd0);
    check("rst_state_c", {5'd0, dbg_c}, 8'd0);
    check("rst_state_d", {7'd0, dbg_d}, 8'd0);
    drive(0, 1);
    drive(0, 0);
    check("prefix_10_a", {5'd0, dbg_a}, 8'd2);
    drive(0, 1);   // "101" falls back to prefix "1", not IDLE
    check("fallback_a", {5'd0, dbg_a}, 8'd1);

    // hand sequence: long zero run keeps c high, a single 1 restarts the count
    drive(1, 0);
    for (int i = 1; i <= 25; i++) begin
      drive(0, 0);
      check($sformatf("zrun%0d_c", i), {7'd0, act[2]}, {7'd0, logic'(i >= 5)});
    end
    drive(0, 1);
    check("zbreak_c", {7'd0, act[2]}, 8'd0);
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0);
      check($sformatf("zrestart%0d_c", i), {7'd0, act[2]}, {7'd0, logic'(i == 5)});
    end

    // randomized stream against the window model
    drive(1, 0);
    for (int i = 0; i < 1000; i++) begin
      logic r;
      logic d;
      r = ($urandom_range(0, 63) == 0);
      if ((i % 200) < 50) d = ($urandom_range(0, 7) == 0);
      else                d = 1'($urandom_range(0, 1));
      drive(r, d);
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back({7'd0, mexp[k]});
        check($sformatf("rnd%0d_%s", i, nm[k]), {7'd0, act[k]}, exp_q.pop_front());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
